// File: rtl/sim_ram_2p.sv
// Dual-port synchronous SRAM model: one masked write port, one pipelined read port.
// Generalised ITCM/DTCM backing store with collision modes and range errors.
module sim_ram_2p #(
    parameter int unsigned DP           = 512,
    parameter int unsigned DW           = 32,
    parameter int unsigned MW           = 4,
    parameter int unsigned AW           = 9,
    parameter int unsigned RD_LAT       = 1,
    parameter int unsigned WR_MODE      = 0,
    parameter int unsigned FORCE_X2ZERO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [MW-1:0] wr_mask,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_err,
    output logic          wr_err
);

    localparam logic [AW:0] DP_L = (AW+1)'(DP);

    if (RD_LAT == 0 || RD_LAT > 4) begin : g_bad_lat
        $fatal(1, "sim_ram_2p: RD_LAT must be in 1..4");
    end

    logic [DW-1:0] mem [0:DP-1];

    logic [DW-1:0] bmask;
    logic          wr_ok;
    logic          rd_ok;
    logic [DW-1:0] rd_word_d;

    // The top lane absorbs any bits beyond the last full byte.
    for (genvar b = 0; b < DW; b++) begin : g_bm
        localparam int unsigned L = ((b / 8) < MW) ? (b / 8) : (MW - 1);
        assign bmask[b] = wr_mask[L];
    end

    assign wr_ok = wr_en & ({1'b0, wr_addr} < DP_L);
    assign rd_ok = {1'b0, rd_addr} < DP_L;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= (mem[wr_addr] & ~bmask) | (wr_data & bmask);
        end
    end

    always_comb begin
        rd_word_d = '0;
        if (rd_ok) begin
            rd_word_d = mem[rd_addr];
            if (WR_MODE != 0 && wr_ok && wr_addr == rd_addr) begin
                rd_word_d = (rd_word_d & ~bmask) | (wr_data & bmask);
            end
        end
    end

    logic [RD_LAT-1:0] v_q;
    logic [RD_LAT-1:0] e_q;
    logic [DW-1:0]     d_q [RD_LAT];
    logic              wr_err_q;

    // Data only advances with a valid token so the last stage holds its value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q      <= '0;
            e_q      <= '0;
            wr_err_q <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q[0]   <= rd_en;
            e_q[0]   <= rd_en & ~rd_ok;
            wr_err_q <= wr_en & ~wr_ok;
            if (rd_en) begin
                d_q[0] <= rd_word_d;
            end
            for (int k = 1; k < RD_LAT; k++) begin
                v_q[k] <= v_q[k-1];
                e_q[k] <= e_q[k-1];
                if (v_q[k-1]) begin
                    d_q[k] <= d_q[k-1];
                end
            end
        end
    end

    assign rd_valid = v_q[RD_LAT-1];
    assign rd_err   = e_q[RD_LAT-1];
    assign wr_err   = wr_err_q;

`ifndef SYNTHESIS
    if (FORCE_X2ZERO != 0) begin : g_x2z
        for (genvar b = 0; b < DW; b++) begin : g_bit
            assign rd_data[b] = (d_q[RD_LAT-1][b] === 1'b1);
        end
    end else begin : g_pass
        assign rd_data = d_q[RD_LAT-1];
    end
`else
    assign rd_data = d_q[RD_LAT-1];
`endif

endmodule

// File: tb/tb_sim_ram_2p.sv
// Scoreboard bench for sim_ram_2p: three configurations share one stimulus
// stream and are checked against an array-based reference model.
module tb_sim_ram_2p;

    typedef struct {
        int          due;
        logic [31:0] d;
        logic        e;
    } exp_t;

    localparam int N = 3;
    localparam int DPV  [N] = '{512, 500, 500};
    localparam int LATV [N] = '{1, 2, 4};
    localparam int WMV  [N] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_mask = '0;
    logic        rd_en = 1'b0;
    logic [8:0]  rd_addr = '0;

    logic [31:0] rdd [N];
    logic        rdv [N];
    logic        rde [N];
    logic        wre [N];

    logic [31:0] mdl [N][512];
    exp_t        rq [N][$];
    int          wq [N][$];
    logic [31:0] last [N];

    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    sim_ram_2p #(.DP(512), .RD_LAT(1), .WR_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_valid(rdv[0]),
        .rd_err(rde[0]), .wr_err(wre[0])
    );

    sim_ram_2p #(.DP(500), .RD_LAT(2), .WR_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_valid(rdv[1]),
        .rd_err(rde[1]), .wr_err(wre[1])
    );

    sim_ram_2p #(.DP(500), .RD_LAT(4), .WR_MODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mask(wr_mask), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rdd[2]), .rd_valid(rdv[2]),
        .rd_err(rde[2]), .wr_err(wre[2])
    );

    function automatic logic [31:0] merge(logic [31:0] old,
                                          logic [31:0] nw,
                                          logic [3:0]  m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    task automatic cmp(string nm, int i, logic [31:0] got, logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s u%0d cyc=%0d got=%h exp=%h", nm, i, cyc, got, exp);
        end
    endtask

    // Monitor: samples 2 time units after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            for (int i = 0; i < N; i++) begin
                logic expv;
                logic expw;
                exp_t e;
                expv = (rq[i].size() > 0) && (rq[i][0].due == cyc);
                cmp("rd_valid", i, 32'(rdv[i]), 32'(expv));
                if (expv) begin
                    e = rq[i].pop_front();
                    if (rdv[i]) begin
                        cmp("rd_data", i, rdd[i], e.d);
                        cmp("rd_err", i, 32'(rde[i]), 32'(e.e));
                    end
                    last[i] = e.d;
                end else begin
                    cmp("rd_hold", i, rdd[i], last[i]);
                    cmp("rd_err_idle", i, 32'(rde[i]), 32'd0);
                end
                expw = (wq[i].size() > 0) && (wq[i][0] == cyc);
                if (expw) void'(wq[i].pop_front());
                cmp("wr_err", i, 32'(wre[i]), 32'(expw));
            end
        end
    end

    task automatic step(logic we, logic [8:0] wa, logic [31:0] wd,
                        logic [3:0] wm, logic re, logic [8:0] ra);
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_mask = wm;
        rd_en   = re;
        rd_addr = ra;
        for (int i = 0; i < N; i++) begin
            exp_t e;
            if (re) begin
                e.due = cyc + LATV[i];
                e.e   = (int'(ra) >= DPV[i]);
                if (e.e) e.d = '0;
                else if (WMV[i] == 1 && we && wa == ra) e.d = merge(mdl[i][ra], wd, wm);
                else e.d = mdl[i][ra];
                rq[i].push_back(e);
            end
            if (we) begin
                if (int'(wa) < DPV[i]) mdl[i][wa] = merge(mdl[i][wa], wd, wm);
                else wq[i].push_back(cyc + 1);
            end
        end
    endtask

    task automatic idle(int n);
        repeat (n) step(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            rq[i].delete();
            wq[i].delete();
            last[i] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) last[i] = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int a = 0; a < 512; a++) step(1'b1, 9'(a), $urandom, 4'hF, 1'b0, '0);

        step(1'b1, 9'd5, 32'hDEADBEEF, 4'hF, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 9'd5);
        step(1'b1, 9'd5, 32'h11223344, 4'b0101, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 9'd5);
        step(1'b1, 9'd5, 32'hCAFEF00D, 4'h0, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 9'd5);

        step(1'b1, 9'd7, 32'hAAAAAAAA, 4'hF, 1'b0, '0);
        step(1'b1, 9'd7, 32'h55555555, 4'b0011, 1'b1, 9'd7);
        step(1'b0, '0, '0, '0, 1'b1, 9'd7);
        idle(5);

        for (int a = 0; a < 8; a++) step(1'b0, '0, '0, '0, 1'b1, 9'(a));
        idle(6);

        step(1'b1, 9'd510, 32'h12345678, 4'hF, 1'b0, '0);
        step(1'b0, '0, '0, '0, 1'b1, 9'd510);
        step(1'b1, 9'd499, 32'h0BADCAFE, 4'hF, 1'b1, 9'd500);
        step(1'b0, '0, '0, '0, 1'b1, 9'd499);
        idle(6);

        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic        re;
            logic [8:0]  wa;
            logic [8:0]  ra;
            we = ($urandom_range(0, 1) == 1);
            re = ($urandom_range(0, 9) < 7);
            wa = 9'($urandom_range(0, 511));
            ra = ($urandom_range(0, 3) == 0) ? wa : 9'($urandom_range(0, 511));
            step(we, wa, $urandom, 4'($urandom_range(0, 15)), re, ra);
        end
        idle(6);

        step(1'b0, '0, '0, '0, 1'b1, 9'd5);
        step(1'b0, '0, '0, '0, 1'b1, 9'd7);
        pulse_reset();
        idle(6);
        step(1'b0, '0, '0, '0, 1'b1, 9'd5);
        step(1'b0, '0, '0, '0, 1'b1, 9'd7);
        idle(8);

        for (int i = 0; i < N; i++) begin
            cmp("drain_rd", i, 32'(rq[i].size()), 32'd0);
            cmp("drain_wr", i, 32'(wq[i].size()), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
